// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: walks one shared 4-bit compare slice over a 4*NIBBLES-bit operand pair, MSB nibble first;
// done pulses k+1 cycles after start for k nibbles, start ignored while busy. CMP_SIGNED_EN adds signed_cmp.
module cmp_seq_ctrl #(
  parameter int NIBBLES    = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] i1,
  input  logic [4*NIBBLES-1:0] i2,
`ifdef CMP_SIGNED_EN
  input  logic                 signed_cmp,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 less,
  output logic                 greater,
  output logic                 equal,
  output logic [2:0]           nib_cnt,
  output logic [3:0]           slc_a,
  output logic [3:0]           slc_b,
  input  logic                 slc_less,
  input  logic                 slc_greater,
  input  logic                 slc_equal
);
  localparam int         W        = 4 * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);
  localparam logic [2:0] NIB3     = 3'(NIBBLES);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0] r_a, r_b;
  logic [2:0]   r_idx;
  logic [2:0]   r_nib_cnt;
  logic         r_stk_lt, r_stk_gt;
  logic         r_less, r_greater, r_equal;
  logic         r_signed;

  logic         w_gt, w_lt, w_early, w_fin, w_accept, w_flip, w_signed_in;
  logic         w_fin_gt, w_fin_lt;
  logic [3:0]   w_nib_a, w_nib_b;

`ifdef CMP_SIGNED_EN
  assign w_signed_in = signed_cmp;
`else
  assign w_signed_in = 1'b0;
`endif

  // Only a one-hot slice answer counts as ordered; anything else reads as equal.
  assign w_gt     = slc_greater & ~slc_less & ~slc_equal;
  assign w_lt     = slc_less & ~slc_greater & ~slc_equal;
  assign w_early  = (EARLY_EXIT != 0) && (w_gt || w_lt);
  assign w_fin    = w_early || (r_idx == 3'd0);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_flip   = r_signed && (r_idx == LAST_IDX);
  assign w_fin_gt = r_stk_gt | (~r_stk_lt & w_gt);
  assign w_fin_lt = r_stk_lt | (~r_stk_gt & w_lt);

  always_comb begin
    w_nib_a = 4'd0;
    w_nib_b = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == 3'(n)) begin
        w_nib_a = r_a[4*n +: 4];
        w_nib_b = r_b[4*n +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CMP;
      S_CMP:   if (w_fin) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flipping bit 3 of the top nibble maps two's-complement order onto unsigned order.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    slc_a = 4'd0;
    slc_b = 4'd0;
    case (r_state)
      S_CMP: begin
        busy  = 1'b1;
        slc_a = {w_nib_a[3] ^ w_flip, w_nib_a[2:0]};
        slc_b = {w_nib_b[3] ^ w_flip, w_nib_b[2:0]};
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= LAST_IDX;
      r_stk_lt  <= 1'b0;
      r_stk_gt  <= 1'b0;
      r_less    <= 1'b0;
      r_greater <= 1'b0;
      r_equal   <= 1'b0;
      r_nib_cnt <= 3'd0;
      r_signed  <= 1'b0;
    end else if (w_accept) begin
      r_a      <= i1;
      r_b      <= i2;
      r_idx    <= LAST_IDX;
      r_stk_lt <= 1'b0;
      r_stk_gt <= 1'b0;
      r_signed <= w_signed_in;
    end else if (r_state == S_CMP) begin
      if (w_early) begin
        r_greater <= w_gt;
        r_less    <= w_lt;
        r_equal   <= 1'b0;
        r_nib_cnt <= NIB3 - r_idx;
      end else if (r_idx == 3'd0) begin
        r_greater <= w_fin_gt;
        r_less    <= w_fin_lt;
        r_equal   <= ~(w_fin_gt | w_fin_lt);
        r_nib_cnt <= NIB3;
      end else begin
        r_idx <= r_idx - 3'd1;
        // The first unequal nibble wins; later nibbles cannot overturn it.
        if (!(r_stk_lt || r_stk_gt)) begin
          r_stk_gt <= w_gt;
          r_stk_lt <= w_lt;
        end
      end
    end
  end

  assign less    = r_less;
  assign greater = r_greater;
  assign equal   = r_equal;
  assign nib_cnt = r_nib_cnt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: one early-exit and one full-scan instance share stimulus, each driving its own slice model.
`timescale 1ns/1ps
module tb_cmp_seq_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] i1    = '0;
  logic [W-1:0] i2    = '0;
  logic         sg_in = 1'b0;

  logic       busy_e, done_e, less_e, greater_e, equal_e;
  logic [2:0] nib_e;
  logic [3:0] sa_e, sb_e;
  logic       busy_f, done_f, less_f, greater_f, equal_f;
  logic [2:0] nib_f;
  logic [3:0] sa_f, sb_f;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.NIBBLES(NIB), .EARLY_EXIT(1)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .i1(i1), .i2(i2),
`ifdef CMP_SIGNED_EN
    .signed_cmp(sg_in),
`endif
    .busy(busy_e), .done(done_e), .less(less_e), .greater(greater_e), .equal(equal_e),
    .nib_cnt(nib_e), .slc_a(sa_e), .slc_b(sb_e),
    .slc_less(sa_e < sb_e), .slc_greater(sa_e > sb_e), .slc_equal(sa_e == sb_e)
  );

  cmp_seq_ctrl #(.NIBBLES(NIB), .EARLY_EXIT(0)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .i1(i1), .i2(i2),
`ifdef CMP_SIGNED_EN
    .signed_cmp(sg_in),
`endif
    .busy(busy_f), .done(done_f), .less(less_f), .greater(greater_f), .equal(equal_f),
    .nib_cnt(nib_f), .slc_a(sa_f), .slc_b(sb_f),
    .slc_less(sa_f < sb_f), .slc_greater(sa_f > sb_f), .slc_equal(sa_f == sb_f)
  );

  // Whole-word reference: ordering from arithmetic compare, nibble count from first differing nibble.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                input logic ee, output logic lt, output logic gt, output logic eq,
                                output int k);
    logic signed [W:0] sa, sb;
    logic found;
    sa = $signed({sg & a[W-1], a});
    sb = $signed({sg & b[W-1], b});
    lt = (sa < sb);
    gt = (sa > sb);
    eq = (sa == sb);
    k = NIB;
    found = 1'b0;
    if (ee) begin
      for (int n = NIB - 1; n >= 0; n--) begin
        if (!found && (a[4*n +: 4] != b[4*n +: 4])) begin
          found = 1'b1;
          k = NIB - n;
        end
      end
    end
  endfunction

  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input string tag);
    logic xlt, xgt, xeq;
    int xk [2];
    int first [2];
    int ndone [2];
    logic [3:0] xa, xb, ga, gb;
    logic glt, ggt, geq, gbusy, gdone;
    logic [2:0] gnib;
    model(a, b, sg, 1'b1, xlt, xgt, xeq, xk[0]);
    model(a, b, sg, 1'b0, xlt, xgt, xeq, xk[1]);
    xa = a[W-1 -: 4] ^ {sg, 3'b000};
    xb = b[W-1 -: 4] ^ {sg, 3'b000};
    first = '{0, 0};
    ndone = '{0, 0};
    @(negedge clk);
    i1 = a; i2 = b; sg_in = sg; start = 1'b1;
    for (int c = 1; c <= NIB + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        gdone = d ? done_f : done_e;
        gbusy = d ? busy_f : busy_e;
        ga    = d ? sa_f : sa_e;
        gb    = d ? sb_f : sb_e;
        if (gdone) begin
          ndone[d]++;
          if (first[d] == 0) first[d] = c;
        end
        if (c == 1) begin
          n_chk += 3;
          if (gbusy !== 1'b1) begin n_fail++; $display("FAIL %s dut%0d busy: got %b want 1", tag, d, gbusy); end
          if (ga !== xa) begin n_fail++; $display("FAIL %s dut%0d slc_a: got %h want %h", tag, d, ga, xa); end
          if (gb !== xb) begin n_fail++; $display("FAIL %s dut%0d slc_b: got %h want %h", tag, d, gb, xb); end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      glt  = d ? less_f : less_e;
      ggt  = d ? greater_f : greater_e;
      geq  = d ? equal_f : equal_e;
      gnib = d ? nib_f : nib_e;
      n_chk += 4;
      if (ndone[d] !== 1) begin n_fail++; $display("FAIL %s dut%0d done_pulses: got %0d want 1", tag, d, ndone[d]); end
      if (first[d] !== xk[d] + 1) begin n_fail++; $display("FAIL %s dut%0d latency: got %0d want %0d", tag, d, first[d], xk[d] + 1); end
      if ({glt, ggt, geq} !== {xlt, xgt, xeq}) begin
        n_fail++; $display("FAIL %s dut%0d lt/gt/eq: got %b%b%b want %b%b%b", tag, d, glt, ggt, geq, xlt, xgt, xeq);
      end
      if (gnib !== 3'(xk[d])) begin n_fail++; $display("FAIL %s dut%0d nib_cnt: got %0d want %0d", tag, d, gnib, xk[d]); end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (d == 0 && {busy_e, done_e, less_e, greater_e, equal_e, nib_e, sa_e, sb_e} !== '0) begin
        n_fail++; $display("FAIL %s dut0 outputs: got %b %b %b%b%b %0d %h %h want all 0", tag,
                           busy_e, done_e, less_e, greater_e, equal_e, nib_e, sa_e, sb_e);
      end
      if (d == 1 && {busy_f, done_f, less_f, greater_f, equal_f, nib_f, sa_f, sb_f} !== '0) begin
        n_fail++; $display("FAIL %s dut1 outputs: got %b %b %b%b%b %0d %h %h want all 0", tag,
                           busy_f, done_f, less_f, greater_f, equal_f, nib_f, sa_f, sb_f);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_cmp(16'h8000, 16'h7FFF, 1'b0, "msb_differs");
    run_cmp(16'h1234, 16'h1234, 1'b0, "equal");
    run_cmp(16'h1230, 16'h1235, 1'b0, "lsb_differs");
    run_cmp(16'h0000, 16'hFFFF, 1'b0, "zero_vs_ones");
  endtask

  task automatic test_reset_mid_op();
    int nd;
    nd = 0;
    @(negedge clk);
    i1 = 16'h1234; i2 = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_op_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_e || done_f || busy_e || busy_f) nd++;
    end
    n_chk++;
    if (nd !== 0) begin n_fail++; $display("FAIL mid_op_reset activity: got %0d cycles want 0", nd); end
    run_cmp(16'h1234, 16'h1234, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int nd [2];
    int bad;
    nd = '{0, 0};
    bad = 0;
    @(negedge clk);
    i1 = 16'h1235; i2 = 16'h1230; start = 1'b1;
    for (int c = 1; c <= NIB + 8; c++) begin
      @(negedge clk);
      start = (c == 2) || (c == NIB + 1);
      if (c == 2) begin i1 = 16'h0001; i2 = 16'h0002; end
      if (done_e) nd[0]++;
      if (done_f) nd[1]++;
      if (c >= NIB + 2) begin
        if (busy_e || busy_f || {less_e, greater_e, equal_e} !== 3'b010 || {less_f, greater_f, equal_f} !== 3'b010) bad++;
      end
    end
    n_chk += 4;
    if (nd[0] !== 1) begin n_fail++; $display("FAIL busy_start dut0 done_pulses: got %0d want 1", nd[0]); end
    if (nd[1] !== 1) begin n_fail++; $display("FAIL busy_start dut1 done_pulses: got %0d want 1", nd[1]); end
    if (bad !== 0) begin n_fail++; $display("FAIL busy_start hold: got %0d bad cycles want 0", bad); end
    if (nib_e !== 3'd4 || nib_f !== 3'd4) begin
      n_fail++; $display("FAIL busy_start nib_cnt: got %0d/%0d want 4/4", nib_e, nib_f);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, m;
    logic sg;
    for (int it = 0; it < 40; it++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = W'($urandom);
        1: b = a;
        default: begin
          m = W'($urandom_range(1, 15));
          b = a ^ (m << (4 * $urandom_range(0, NIB - 1)));
        end
      endcase
`ifdef CMP_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      run_cmp(a, b, sg, "random");
    end
  endtask

`ifdef CMP_SIGNED_EN
  task automatic test_signed();
    run_cmp(16'hFFFF, 16'h0001, 1'b1, "signed_neg");
    n_chk++;
    if ({less_e, nib_e} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL signed_neg direct: got less=%b nib=%0d want less=1 nib=1", less_e, nib_e);
    end
    run_cmp(16'hFFFF, 16'h0001, 1'b0, "unsigned_big");
    n_chk++;
    if (greater_e !== 1'b1) begin n_fail++; $display("FAIL unsigned_big direct: got greater=%b want 1", greater_e); end
    run_cmp(16'h7000, 16'h8000, 1'b1, "signed_pos_vs_neg");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef CMP_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
